// File: rtl/cc_tag_fill_writer.sv
// Cache-line refill engine: fetches a line over the memory read channel, streams beats into
// the data SRAM, then writes {valid, tag} into the tag SRAM. CC_FILL_INVALIDATE_EN adds an invalidate port.
module cc_tag_fill_writer #(
   parameter int DATA_W = 64,
   parameter int BEATS  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     miss_i,
   input  logic [16:0]              tag_i,
   input  logic [8:0]               index_i,
   output logic                     busy_o,
   output logic [31:0]              mem_araddr_o,
   output logic                     mem_arvalid_o,
   input  logic                     mem_arready_i,
   input  logic [DATA_W-1:0]        mem_rdata_i,
   input  logic                     mem_rvalid_i,
   input  logic                     mem_rlast_i,
   output logic                     mem_rready_o,
   output logic                     data_wren_o,
   output logic [8:0]               data_windex_o,
   output logic [$clog2(BEATS)-1:0] data_wbeat_o,
   output logic [DATA_W-1:0]        data_wdata_o,
   output logic                     tag_wren_o,
   output logic [8:0]               tag_windex_o,
   output logic [17:0]              tag_wdata_o,
   output logic                     fill_done_o,
   output logic                     rlast_err_o
`ifdef CC_FILL_INVALIDATE_EN
   ,
   input  logic                     inv_valid_i,
   input  logic [8:0]               inv_index_i,
   output logic                     inv_ready_o
`endif
);
   localparam int BW = $clog2(BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_TAG, S_INV} state_t;

   state_t          r_state, w_next;
   logic [16:0]     r_tag;
   logic [8:0]      r_index;
   logic [BW-1:0]   r_beat;
   logic            r_err;
   logic            w_beat_acc;
   logic            w_last_beat;
`ifdef CC_FILL_INVALIDATE_EN
   logic [8:0]      r_inv_index;
   logic            w_inv_acc;

   assign inv_ready_o = (r_state == S_IDLE) && !miss_i;
   assign w_inv_acc   = inv_ready_o && inv_valid_i;
`endif

   assign w_beat_acc  = (r_state == S_DATA) && mem_rvalid_i;
   assign w_last_beat = (r_beat == LAST_BEAT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (miss_i) w_next = S_REQ;
`ifdef CC_FILL_INVALIDATE_EN
            else if (inv_valid_i) w_next = S_INV;
`endif
         end
         S_REQ:  if (mem_arready_i) w_next = S_DATA;
         // beat count alone ends the burst, whatever rlast says
         S_DATA: if (w_beat_acc && w_last_beat) w_next = S_TAG;
         S_TAG:  w_next = S_IDLE;
         S_INV:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tag   <= '0;
         r_index <= '0;
         r_beat  <= '0;
         r_err   <= 1'b0;
`ifdef CC_FILL_INVALIDATE_EN
         r_inv_index <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && miss_i) begin
            r_tag   <= tag_i;
            r_index <= index_i;
            r_beat  <= '0;
         end
         if (w_beat_acc) begin
            r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
            if (mem_rlast_i != w_last_beat) r_err <= 1'b1;
         end
`ifdef CC_FILL_INVALIDATE_EN
         if (w_inv_acc) r_inv_index <= inv_index_i;
`endif
      end
   end

   assign busy_o        = (r_state != S_IDLE);
   assign mem_araddr_o  = {r_tag, r_index, 6'b0};
   assign mem_arvalid_o = (r_state == S_REQ);
   assign mem_rready_o  = (r_state == S_DATA);
   assign data_wren_o   = w_beat_acc;
   assign data_windex_o = w_beat_acc ? r_index : '0;
   assign data_wbeat_o  = w_beat_acc ? r_beat : '0;
   assign data_wdata_o  = w_beat_acc ? mem_rdata_i : '0;
   assign fill_done_o   = (r_state == S_TAG);
   assign rlast_err_o   = r_err;

   always_comb begin
      tag_wren_o   = 1'b0;
      tag_windex_o = '0;
      tag_wdata_o  = '0;
      if (r_state == S_TAG) begin
         tag_wren_o   = 1'b1;
         tag_windex_o = r_index;
         tag_wdata_o  = {1'b1, r_tag};
      end
`ifdef CC_FILL_INVALIDATE_EN
      else if (r_state == S_INV) begin
         tag_wren_o   = 1'b1;
         tag_windex_o = r_inv_index;
      end
`endif
   end
endmodule

// File: tb/tb_cc_tag_fill_writer.sv
// Self-checking bench for cc_tag_fill_writer: transaction-level reference model compared every
// cycle, plus literal checks of latency, addresses and tag words. Honours CC_FILL_INVALIDATE_EN.
module tb_cc_tag_fill_writer;
   localparam int DW = 64;
   localparam int NB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, miss, arready, rvalid, rlast;
   logic [16:0]   tag;
   logic [8:0]    idx;
   logic [DW-1:0] rdata;
   logic          busy_o, mem_arvalid_o, mem_rready_o, data_wren_o, tag_wren_o, fill_done_o, rlast_err_o;
   logic [31:0]   mem_araddr_o;
   logic [8:0]    data_windex_o, tag_windex_o;
   logic [2:0]    data_wbeat_o;
   logic [DW-1:0] data_wdata_o;
   logic [17:0]   tag_wdata_o;
`ifdef CC_FILL_INVALIDATE_EN
   logic          inv_valid, inv_ready;
   logic [8:0]    inv_index;
`endif

   cc_tag_fill_writer #(.DATA_W(DW), .BEATS(NB)) dut (
      .clk(clk), .rst(rst), .miss_i(miss), .tag_i(tag), .index_i(idx), .busy_o(busy_o),
      .mem_araddr_o(mem_araddr_o), .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(arready),
      .mem_rdata_i(rdata), .mem_rvalid_i(rvalid), .mem_rlast_i(rlast), .mem_rready_o(mem_rready_o),
      .data_wren_o(data_wren_o), .data_windex_o(data_windex_o), .data_wbeat_o(data_wbeat_o),
      .data_wdata_o(data_wdata_o), .tag_wren_o(tag_wren_o), .tag_windex_o(tag_windex_o),
      .tag_wdata_o(tag_wdata_o), .fill_done_o(fill_done_o), .rlast_err_o(rlast_err_o)
`ifdef CC_FILL_INVALIDATE_EN
      , .inv_valid_i(inv_valid), .inv_index_i(inv_index), .inv_ready_o(inv_ready)
`endif
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a fill is "active" from the miss until the tag write; within it the
   // request is either outstanding or done, and beats are counted 0..NB.
   bit          started = 0;
   bit          m_act = 0, m_ard = 0, m_err = 0, m_inv = 0;
   int          m_nb = 0;
   logic [16:0] m_tag = '0;
   logic [8:0]  m_idx = '0, m_inv_idx = '0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         started <= 1; m_act <= 0; m_ard <= 0; m_err <= 0; m_inv <= 0; m_nb <= 0;
         m_tag <= '0; m_idx <= '0; m_inv_idx <= '0;
      end else if (m_inv) begin
         m_inv <= 0;
      end else if (!m_act) begin
         if (miss) begin
            m_act <= 1; m_ard <= 0; m_nb <= 0; m_tag <= tag; m_idx <= idx;
         end
`ifdef CC_FILL_INVALIDATE_EN
         else if (inv_valid) begin
            m_inv <= 1; m_inv_idx <= inv_index;
         end
`endif
      end else if (!m_ard) begin
         if (arready) m_ard <= 1;
      end else if (m_nb < NB) begin
         if (rvalid) begin
            if (rlast != (m_nb == NB - 1)) m_err <= 1;
            m_nb <= m_nb + 1;
         end
      end else begin
         m_act <= 0;
      end
   end

   // Observation counters, read by the stimulus as differences
   int          n_wr = 0, n_ar = 0, n_chg = 0, n_done = 0, done_cyc = 0;
   logic [31:0] ar_addr = '0;
   logic [17:0] last_tagw = '0;

   always @(negedge clk) begin
      logic       e_req, e_data, e_tag, e_wr, e_busy, e_twr;
      logic [8:0] e_tix;
      if (started) begin
         e_req  = m_act && !m_ard;
         e_data = m_act && m_ard && (m_nb < NB);
         e_tag  = m_act && m_ard && (m_nb == NB);
         e_wr   = e_data && rvalid;
         e_busy = m_act || m_inv;
         e_twr  = e_tag || m_inv;
         e_tix  = e_tag ? m_idx : (m_inv ? m_inv_idx : 9'h0);
         chk("busy", busy_o, e_busy);
         chk("arvalid", mem_arvalid_o, e_req);
         chk("araddr", mem_araddr_o, {m_tag, m_idx, 6'b0});
         chk("rready", mem_rready_o, e_data);
         chk("data_wren", data_wren_o, e_wr);
         chk("data_windex", data_windex_o, e_wr ? m_idx : 9'h0);
         chk("data_wbeat", data_wbeat_o, e_wr ? 3'(m_nb) : 3'h0);
         chk("data_wdata", data_wdata_o, e_wr ? rdata : 64'h0);
         chk("tag_wren", tag_wren_o, e_twr);
         chk("tag_windex", tag_windex_o, e_tix);
         chk("tag_wdata", tag_wdata_o, e_tag ? {1'b1, m_tag} : 18'h0);
         chk("fill_done", fill_done_o, e_tag);
         chk("rlast_err", rlast_err_o, m_err);
`ifdef CC_FILL_INVALIDATE_EN
         chk("inv_ready", inv_ready, !e_busy && !miss);
`endif
         if (data_wren_o) n_wr++;
         if (mem_arvalid_o) begin
            if (n_ar > 0 && mem_araddr_o != ar_addr) n_chg++;
            n_ar++;
            ar_addr = mem_araddr_o;
         end
         if (fill_done_o) begin
            n_done++;
            done_cyc = cyc;
            last_tagw = tag_wdata_o;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int b_wr, b_ar, b_chg, b_done, miss_cyc;

   // mode 0: all ready; 1: arready late + rvalid gaps; 2: extra miss mid-data;
   // 3: rlast on beat 3; 4: random; 5: reset after beat 4
   task automatic do_fill(input logic [16:0] t, input logic [8:0] ix, input int mode);
      int  tc = 0;
      bit  go = 1;
      b_wr = n_wr; b_ar = n_ar; b_chg = n_chg; b_done = n_done; miss_cyc = cyc;
      while (go) begin
         miss    = (tc == 0) || (mode == 2 && tc == 4) ||
                   (mode == 4 && tc > 0 && tc < 6 && $urandom_range(1) == 1);
         tag     = (tc == 0) ? t : 17'($urandom);
         idx     = (tc == 0) ? ix : 9'($urandom);
         arready = (mode == 1) ? (tc >= 4) : (mode == 4) ? 1'($urandom_range(1)) : 1'b1;
         rvalid  = (mode == 1) ? (tc % 2 == 1) : (mode == 4) ? 1'($urandom_range(1)) : 1'b1;
         rlast   = (mode == 3) ? (m_nb == 3)
                 : ((m_nb == NB - 1) ^ (mode == 4 && $urandom_range(15) == 0));
         rdata   = {$urandom, $urandom};
         rst     = (mode == 5 && m_nb == 5);
         if (rst) rvalid = 1'b0;
         tick;
         if (rst) begin
            rst = 1'b0; go = 0;
         end else if (!m_act) begin
            go = 0;
         end
         tc++;
         if (tc > 300) begin
            chk("fill_timeout", 1, 0);
            go = 0;
         end
      end
      miss = 0; arready = 0; rvalid = 0; rlast = 0;
   endtask

   initial begin
      rst = 1; miss = 0; arready = 0; rvalid = 0; rlast = 0; tag = '0; idx = '0; rdata = '0;
`ifdef CC_FILL_INVALIDATE_EN
      inv_valid = 0; inv_index = '0;
`endif
      tick; tick;
      rst = 0;
      tick;
      chk("reset_busy", busy_o, 0);
      chk("reset_araddr", mem_araddr_o, 0);
      chk("reset_err", rlast_err_o, 0);

      do_fill(17'h1ABCD, 9'h05A, 0);
      chk("t1_latency", done_cyc - miss_cyc, 10);
      chk("t1_writes", n_wr - b_wr, 8);
      chk("t1_ar_cycles", n_ar - b_ar, 1);
      chk("t1_araddr", ar_addr, 32'hD5E6_9680);
      chk("t1_tagw", last_tagw, 18'h3ABCD);
      chk("t1_done", n_done - b_done, 1);

      do_fill(17'h1ABCD, 9'h05A, 1);
      chk("t2_ar_cycles", n_ar - b_ar, 4);
      chk("t2_addr_stable", n_chg - b_chg, 0);
      chk("t2_writes", n_wr - b_wr, 8);
      chk("t2_done", n_done - b_done, 1);

      do_fill(17'h1ABCD, 9'h05A, 2);
      chk("t3_done", n_done - b_done, 1);
      chk("t3_ar_cycles", n_ar - b_ar, 1);
      chk("t3_tagw", last_tagw, 18'h3ABCD);

      do_fill(17'h00F0F, 9'h100, 3);
      chk("t4_err", rlast_err_o, 1);
      chk("t4_writes", n_wr - b_wr, 8);
      chk("t4_done", n_done - b_done, 1);
      do_fill(17'h00F0F, 9'h101, 0);
      chk("t4_sticky", rlast_err_o, 1);

      do_fill(17'h12345, 9'h033, 5);
      chk("t5_done", n_done - b_done, 0);
      chk("t5_writes", n_wr - b_wr, 5);
      chk("t5_busy", busy_o, 0);
      chk("t5_err_clr", rlast_err_o, 0);
      do_fill(17'h00001, 9'h1FF, 0);
      chk("t5_refill_done", n_done - b_done, 1);
      chk("t5_refill_tagw", last_tagw, 18'h20001);

`ifdef CC_FILL_INVALIDATE_EN
      inv_valid = 1; inv_index = 9'h1FF;
      tick;
      inv_valid = 0;
      #1;
      chk("inv_wren", tag_wren_o, 1);
      chk("inv_wdata", tag_wdata_o, 0);
      chk("inv_windex", tag_windex_o, 9'h1FF);
      chk("inv_no_done", fill_done_o, 0);
      tick;
      inv_valid = 1; inv_index = 9'h0AA;
      do_fill(17'h0BEEF, 9'h0AA, 0);
      chk("inv_fill_first", n_done - b_done, 1);
      tick;
      inv_valid = 0;
      #1;
      chk("inv_after_wren", tag_wren_o, 1);
      chk("inv_after_windex", tag_windex_o, 9'h0AA);
      tick;
`endif

      for (int i = 0; i < 30; i++) begin
         do_fill(17'($urandom), 9'($urandom), 4);
         chk("rand_done", n_done - b_done, 1);
         chk("rand_writes", n_wr - b_wr, 8);
      end
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
